// File: rtl/cluster_periph_arb_pkg.sv
// cluster_periph_arb_pkg: shared index/occupancy types for the cluster peripheral arbiter
package cluster_periph_arb_pkg;
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = $clog2(MAX_REQ);
    localparam int OCC_W   = 8;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [OCC_W-1:0] occ_t;

    // (p + i) mod n for p < n and 0 <= i < n
    function automatic idx_t wrap_add(idx_t p, int i, int n);
        int s;
        s = int'(p) + i;
        return idx_t'(s >= n ? s - n : s);
    endfunction
endpackage

// File: rtl/periph_arb_idx_fifo.sv
// periph_arb_idx_fifo: in-order record of which requester owns each outstanding transaction
module periph_arb_idx_fifo
    import cluster_periph_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  idx_t din,
    output idx_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    idx_t          mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    occ_t          cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push = push & (~full | do_pop);
    assign full    = cnt_q == occ_t'(DEPTH);
    assign empty   = cnt_q == '0;
    assign dout    = mem[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_q] <= din;
                wr_q      <= wr_q + 1'b1;
            end
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + occ_t'(do_push) - occ_t'(do_pop);
        end
    end
endmodule

// File: rtl/cluster_periph_arbiter.sv
// cluster_periph_arbiter: round-robin arbiter from cluster requesters onto one peripheral slave,
// routing in-order responses back to the requester that issued each transaction.
module cluster_periph_arbiter
    import cluster_periph_arb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int ID_WIDTH   = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_REQ-1:0]                req_i,
    input  logic [NB_REQ-1:0][31:0]          add_i,
    input  logic [NB_REQ-1:0]                wen_i,
    input  logic [NB_REQ-1:0][31:0]          wdata_i,
    input  logic [NB_REQ-1:0][3:0]           be_i,
    input  logic [NB_REQ-1:0][ID_WIDTH-1:0]  id_i,
    output logic [NB_REQ-1:0]                gnt_o,
    output logic [NB_REQ-1:0]                r_valid_o,
    output logic [31:0]                      r_rdata_o,
    output logic                             r_opc_o,
    output logic [ID_WIDTH-1:0]              r_id_o,
    output logic                             slv_req_o,
    output logic [31:0]                      slv_add_o,
    output logic                             slv_wen_o,
    output logic [31:0]                      slv_wdata_o,
    output logic [3:0]                       slv_be_o,
    output logic [ID_WIDTH-1:0]              slv_id_o,
    input  logic                             slv_gnt_i,
    input  logic                             slv_r_valid_i,
    input  logic [31:0]                      slv_r_rdata_i,
    input  logic                             slv_r_opc_i,
    input  logic [ID_WIDTH-1:0]              slv_r_id_i,
    output logic                             err_o
);
    idx_t ptr_q;
    idx_t sel;
    idx_t head;
    logic full;
    logic empty;
    logic hs;
    logic pop;
    logic err_q;

    always_comb begin
        sel = ptr_q;
        // farthest distance first so the nearest active requester at or after ptr_q wins
        for (int i = NB_REQ - 1; i >= 0; i--)
            for (int k = 0; k < NB_REQ; k++)
                if (req_i[k] && wrap_add(ptr_q, i, NB_REQ) == idx_t'(k))
                    sel = idx_t'(k);
    end

    always_comb begin
        slv_add_o   = '0;
        slv_wen_o   = 1'b0;
        slv_wdata_o = '0;
        slv_be_o    = '0;
        slv_id_o    = '0;
        for (int k = 0; k < NB_REQ; k++)
            if (sel == idx_t'(k)) begin
                slv_add_o   = add_i[k];
                slv_wen_o   = wen_i[k];
                slv_wdata_o = wdata_i[k];
                slv_be_o    = be_i[k];
                slv_id_o    = id_i[k];
            end
    end

    assign slv_req_o = ~rst_i & (|req_i) & ~full;
    assign hs        = slv_req_o & slv_gnt_i;
    assign pop       = ~rst_i & slv_r_valid_i & ~empty;

    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            gnt_o[k]     = hs && sel == idx_t'(k);
            r_valid_o[k] = pop && head == idx_t'(k);
        end
    end

    assign r_rdata_o = slv_r_valid_i ? slv_r_rdata_i : '0;
    assign r_opc_o   = slv_r_valid_i ? slv_r_opc_i : 1'b0;
    assign r_id_o    = slv_r_valid_i ? slv_r_id_i : '0;
    assign err_o     = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (hs)
                ptr_q <= wrap_add(sel, 1, NB_REQ);
            if (slv_r_valid_i && empty)
                err_q <= 1'b1;
        end
    end

    periph_arb_idx_fifo #(.DEPTH(FIFO_DEPTH)) u_idx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (hs),
        .pop   (pop),
        .din   (sel),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_cluster_periph_arbiter.sv
// tb_cluster_periph_arbiter: scoreboard bench with requester/slave models and directed scenarios
module tb_cluster_periph_arbiter;
    localparam int NB  = 4;
    localparam int IDW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_i;
    logic [NB-1:0]            req_i;
    logic [NB-1:0][31:0]      add_i;
    logic [NB-1:0]            wen_i;
    logic [NB-1:0][31:0]      wdata_i;
    logic [NB-1:0][3:0]       be_i;
    logic [NB-1:0][IDW-1:0]   id_i;
    logic [NB-1:0]            gnt_o;
    logic [NB-1:0]            r_valid_o;
    logic [31:0]              r_rdata_o;
    logic                     r_opc_o;
    logic [IDW-1:0]           r_id_o;
    logic                     slv_req_o;
    logic [31:0]              slv_add_o;
    logic                     slv_wen_o;
    logic [31:0]              slv_wdata_o;
    logic [3:0]               slv_be_o;
    logic [IDW-1:0]           slv_id_o;
    logic                     slv_gnt_i;
    logic                     slv_r_valid_i;
    logic [31:0]              slv_r_rdata_i;
    logic                     slv_r_opc_i;
    logic [IDW-1:0]           slv_r_id_i;
    logic                     err_o;

    cluster_periph_arbiter #(.NB_REQ(NB), .ID_WIDTH(IDW), .FIFO_DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .add_i         (add_i),
        .wen_i         (wen_i),
        .wdata_i       (wdata_i),
        .be_i          (be_i),
        .id_i          (id_i),
        .gnt_o         (gnt_o),
        .r_valid_o     (r_valid_o),
        .r_rdata_o     (r_rdata_o),
        .r_opc_o       (r_opc_o),
        .r_id_o        (r_id_o),
        .slv_req_o     (slv_req_o),
        .slv_add_o     (slv_add_o),
        .slv_wen_o     (slv_wen_o),
        .slv_wdata_o   (slv_wdata_o),
        .slv_be_o      (slv_be_o),
        .slv_id_o      (slv_id_o),
        .slv_gnt_i     (slv_gnt_i),
        .slv_r_valid_i (slv_r_valid_i),
        .slv_r_rdata_i (slv_r_rdata_i),
        .slv_r_opc_i   (slv_r_opc_i),
        .slv_r_id_i    (slv_r_id_i),
        .err_o         (err_o)
    );

    typedef struct {int k; logic [IDW-1:0] id;} txn_t;
    typedef struct {int due; logic [IDW-1:0] id;} pend_t;

    int             gexp[$];
    txn_t           rexp[$];
    pend_t          pend[$];
    logic [IDW-1:0] ids [NB][8];
    int             head [NB];
    int             tail [NB];
    int             cyc;
    int             lat;
    int             total;
    int             bad;
    logic           inject;

    function automatic logic [31:0] addr_of(int k, logic [IDW-1:0] id);
        return 32'h1A00_0000 | (32'(k) << 8) | 32'(id);
    endfunction

    function automatic logic [31:0] rdata_of(logic [IDW-1:0] id);
        return 32'hC0DE_0000 | 32'(id);
    endfunction

    function automatic logic [73:0] fields_of(int k, logic [IDW-1:0] id);
        return {addr_of(k, id), ~addr_of(k, id), 4'(k + 1), id[0], id};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive();
        pend_t p;
        for (int k = 0; k < NB; k++) begin
            logic [IDW-1:0] id;
            id         = ids[k][head[k] < 8 ? head[k] : 7];
            req_i[k]   = head[k] < tail[k];
            id_i[k]    = id;
            add_i[k]   = addr_of(k, id);
            wdata_i[k] = ~addr_of(k, id);
            be_i[k]    = 4'(k + 1);
            wen_i[k]   = id[0];
        end
        if (inject) begin
            slv_r_valid_i = 1'b1;
            slv_r_id_i    = '1;
            slv_r_rdata_i = 32'h0BAD_0001;
            slv_r_opc_i   = 1'b1;
            inject        = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            p             = pend.pop_front();
            slv_r_valid_i = 1'b1;
            slv_r_id_i    = p.id;
            slv_r_rdata_i = rdata_of(p.id);
            slv_r_opc_i   = p.id[0];
        end else begin
            slv_r_valid_i = 1'b0;
            slv_r_id_i    = '1;
            slv_r_rdata_i = 32'hDEAD_BEEF;
            slv_r_opc_i   = 1'b1;
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            step();
            drive();
        end
    endtask

    task automatic enq(int k, logic [IDW-1:0] id);
        ids[k][tail[k]] = id;
        tail[k]++;
    endtask

    task automatic exp_txn(int k, logic [IDW-1:0] id);
        gexp.push_back(k);
        rexp.push_back('{k, id});
    endtask

    // monitor: consumes expected grants/responses whenever the DUT presents them
    initial begin
        int   e;
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                chk("reset_quiet", {gnt_o, r_valid_o, slv_req_o}, '0);
            end else begin
                if (gnt_o != '0) begin
                    if (gexp.size() == 0) begin
                        chk("gnt_unexpected", gnt_o, '0);
                    end else begin
                        e = gexp.pop_front();
                        chk("gnt_order", gnt_o, 4'b1 << e);
                        chk("slv_fields", {slv_add_o, slv_wdata_o, slv_be_o, slv_wen_o, slv_id_o},
                            fields_of(e, ids[e][head[e]]));
                    end
                    for (int k = 0; k < NB; k++)
                        if (gnt_o[k]) head[k]++;
                end
                if (slv_req_o && slv_gnt_i)
                    pend.push_back('{cyc + lat, slv_id_o});
                if (!slv_r_valid_i) begin
                    chk("idle_resp", {r_valid_o, r_rdata_o, r_opc_o, r_id_o}, '0);
                end else if (rexp.size() == 0) begin
                    chk("orphan_resp", r_valid_o, '0);
                end else begin
                    t = rexp.pop_front();
                    chk("resp", {r_valid_o, r_rdata_o, r_opc_o, r_id_o},
                        {4'b1 << t.k, rdata_of(t.id), t.id[0], t.id});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; slv_gnt_i = 1'b1; lat = 1; inject = 1'b0;
        cyc = 0; total = 0; bad = 0;
        for (int k = 0; k < NB; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        enq(2, 5'd30);
        drive();
        run(2);
        step();
        rst_i = 1'b0; head[2] = 0; tail[2] = 0;
        drive();
        @(negedge clk);
        chk("err_after_reset", err_o, 0);
        chk("no_req_idle", slv_req_o, 0);

        // all four active: 0,1,2,3,0 one per cycle
        step();
        enq(0, 5'd1); enq(1, 5'd2); enq(2, 5'd3); enq(3, 5'd4); enq(0, 5'd5);
        exp_txn(0, 5'd1); exp_txn(1, 5'd2); exp_txn(2, 5'd3); exp_txn(3, 5'd4); exp_txn(0, 5'd5);
        drive();
        run(4);
        step();
        chk("rr_back_to_back", gexp.size(), 0);
        drive();
        run(3);
        chk("rr_drained", rexp.size(), 0);

        // move ptr to 2, then 1 and 3 active -> 3 first
        step();
        enq(1, 5'd6);
        exp_txn(1, 5'd6);
        drive();
        run(3);
        step();
        enq(1, 5'd7); enq(3, 5'd8);
        exp_txn(3, 5'd8); exp_txn(1, 5'd7);
        drive();
        run(4);
        chk("wrap_drained", gexp.size() + rexp.size(), 0);

        // latency 3, three reads from requester 0, FIFO depth 2
        step();
        lat = 3;
        enq(0, 5'd9); enq(0, 5'd10); enq(0, 5'd11);
        exp_txn(0, 5'd9); exp_txn(0, 5'd10); exp_txn(0, 5'd11);
        drive();
        run(1);
        step(); drive();
        @(negedge clk);
        chk("full_blocks_req", {req_i[0], slv_req_o}, 2'b10);
        step(); drive();
        @(negedge clk);
        chk("full_pop_no_req", {slv_req_o, r_valid_o}, 5'b0_0001);
        step(); drive();
        @(negedge clk);
        chk("third_grant_with_pop", {gnt_o, r_valid_o}, 8'b0001_0001);
        run(6);
        chk("lat_drained", gexp.size() + rexp.size(), 0);

        // orphan response sets sticky error
        step();
        inject = 1'b1;
        drive();
        @(negedge clk);
        chk("orphan_no_valid", r_valid_o, 0);
        step(); drive();
        chk("err_set", err_o, 1);
        run(3);
        chk("err_sticky", err_o, 1);

        // reset with two outstanding
        step();
        lat = 2;
        enq(0, 5'd20); enq(0, 5'd21);
        exp_txn(0, 5'd20); exp_txn(0, 5'd21);
        drive();
        run(1);
        step();
        rst_i = 1'b1;
        rexp.delete();
        for (int k = 0; k < NB; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        drive();
        step();
        rst_i = 1'b0;
        drive();
        @(negedge clk);
        chk("err_cleared", err_o, 0);
        step(); drive();
        chk("stale_resp_err", err_o, 1);
        step();
        lat = 1;
        enq(1, 5'd23); enq(0, 5'd22);
        exp_txn(0, 5'd22); exp_txn(1, 5'd23);
        drive();
        run(4);
        chk("ptr_reset_drained", gexp.size() + rexp.size(), 0);
        chk("slave_idle", pend.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
